// File: rtl/l2_tag_ctrl.sv
// l2_tag_ctrl: sequencer for the 4-way, 256-set L2 tag array.
// After reset it sweeps the array and invalidates every way. After that it
// handles one tag operation at a time (lookup, allocate-on-miss, invalidate)
// and keeps a 3-bit tree pseudo-LRU per set.
module l2_tag_ctrl #(
  parameter int TL_AW = 28
) (
  input  logic              l2_clock_i,
  input  logic              l2_reset_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [TL_AW-8:0]  req_line_i,
  input  logic [1:0]        req_op_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_hit_o,
  output logic [1:0]        rsp_way_o,
  output logic              rsp_victim_valid_o,
  output logic              busy_o,
  output logic [TL_AW-8:0]  tag_line_o,
  input  logic [3:0]        tag_set_bitvec_i,
  input  logic              tag_valid_i,
  input  logic [1:0]        tag_set_enc_i,
  output logic [TL_AW-8:0]  tag_ins_line_o,
  output logic [1:0]        tag_ins_way_o,
  output logic              tag_insert_o,
  output logic              tag_insert_present_o
);

  localparam int LW = TL_AW - 7;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_LOOKUP, ST_RESP} state_t;

  typedef struct packed {
    logic [LW-1:0] line;
    logic [1:0]    op;
  } req_t;

  state_t           state;
  req_t             req_q;
  logic [9:0]       sweep_cnt;
  logic [255:0][2:0] plru;

  logic [7:0] idx;
  logic       is_alloc, is_inv;
  logic [2:0] plru_cur;
  logic [1:0] plru_way, free_way, alloc_way, lk_way;
  logic       all_valid, lk_hit, lk_write, lk_touch, lk_victim;

  // b0 picks the half, b1/b2 point at the way to replace inside that half.
  // Touching a way points the tree away from it.
  function automatic logic [2:0] plru_touch(input logic [2:0] cur, input logic [1:0] w);
    logic [2:0] nxt;
    nxt    = cur;
    nxt[0] = ~w[1];
    if (!w[1]) nxt[1] = ~w[0];
    else       nxt[2] = ~w[0];
    return nxt;
  endfunction

  assign idx       = req_q.line[7:0];
  assign is_alloc  = (req_q.op == 2'b01);
  assign is_inv    = (req_q.op == 2'b10);   // 2'b11 falls through as a lookup
  assign plru_cur  = plru[idx];
  assign plru_way  = plru_cur[0] ? (plru_cur[2] ? 2'd3 : 2'd2)
                                 : (plru_cur[1] ? 2'd1 : 2'd0);
  assign all_valid = &tag_set_bitvec_i;
  assign alloc_way = all_valid ? plru_way : free_way;
  assign lk_hit    = tag_valid_i;

  // Lowest-numbered empty way is preferred over evicting anything.
  always_comb begin
    free_way = 2'd3;
    if      (!tag_set_bitvec_i[0]) free_way = 2'd0;
    else if (!tag_set_bitvec_i[1]) free_way = 2'd1;
    else if (!tag_set_bitvec_i[2]) free_way = 2'd2;
  end

  // LOOKUP-cycle decision: which way answers, whether to write, whether to touch.
  always_comb begin
    lk_way    = 2'd0;
    lk_write  = 1'b0;
    lk_touch  = 1'b0;
    lk_victim = 1'b0;
    if (lk_hit) begin
      lk_way   = tag_set_enc_i;
      lk_write = is_inv;
      lk_touch = ~is_inv;
    end else if (is_alloc) begin
      lk_way    = alloc_way;
      lk_write  = 1'b1;
      lk_touch  = 1'b1;
      lk_victim = all_valid;
    end
  end

  assign busy_o      = (state == ST_INIT);
  assign req_ready_o = (state == ST_IDLE);
  assign tag_line_o  = req_q.line;

  // Array write port: sweep writes in INIT, the lookup result writes in LOOKUP.
  // The write result depends on the same-cycle read, so this stays combinational.
  always_comb begin
    tag_insert_o         = 1'b0;
    tag_insert_present_o = 1'b0;
    tag_ins_line_o       = req_q.line;
    tag_ins_way_o        = lk_way;
    if (!l2_reset_i) begin
      case (state)
        ST_INIT: begin
          tag_insert_o   = 1'b1;
          tag_ins_line_o = {{(LW-8){1'b0}}, sweep_cnt[9:2]};
          tag_ins_way_o  = sweep_cnt[1:0];
        end
        ST_LOOKUP: begin
          tag_insert_o         = lk_write;
          tag_insert_present_o = lk_write & ~lk_hit;
        end
        default: ;
      endcase
    end
  end

  // Control FSM with registered response outputs.
  always_ff @(posedge l2_clock_i) begin
    if (l2_reset_i) begin
      state              <= ST_INIT;
      sweep_cnt          <= '0;
      req_q              <= '0;
      rsp_valid_o        <= 1'b0;
      rsp_hit_o          <= 1'b0;
      rsp_way_o          <= 2'd0;
      rsp_victim_valid_o <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          sweep_cnt <= sweep_cnt + 10'd1;
          if (sweep_cnt == 10'd1023) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (req_valid_i) begin
            req_q <= '{line: req_line_i, op: req_op_i};
            state <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          rsp_valid_o        <= 1'b1;
          rsp_hit_o          <= lk_hit;
          rsp_way_o          <= lk_way;
          rsp_victim_valid_o <= lk_victim;
          state              <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  // PLRU storage: cleared by the sweep, updated in the same cycle as the tag write.
  always_ff @(posedge l2_clock_i) begin
    if (!l2_reset_i) begin
      if (state == ST_INIT && sweep_cnt[1:0] == 2'd0)
        plru[sweep_cnt[9:2]] <= 3'b000;
      else if (state == ST_LOOKUP && lk_touch)
        plru[idx] <= plru_touch(plru_cur, lk_way);
    end
  end

endmodule

// File: tb/tb_l2_tag_ctrl.sv
// Directed bench for l2_tag_ctrl with a behavioural tag array attached.
module tb_l2_tag_ctrl;

  localparam int TL_AW = 28;
  localparam int LW    = TL_AW - 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready;
  logic [LW-1:0] req_line;
  logic [1:0]    req_op;
  logic          rsp_valid, rsp_ready, rsp_hit, rsp_vv, busy;
  logic [1:0]    rsp_way;
  logic [LW-1:0] tag_line, ins_line;
  logic [3:0]    m_bitvec;
  logic          m_hit;
  logic [1:0]    m_enc, ins_way;
  logic          ins, ins_pres;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  l2_tag_ctrl #(.TL_AW(TL_AW)) dut (
    .l2_clock_i(clk), .l2_reset_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_line_i(req_line), .req_op_i(req_op),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_hit_o(rsp_hit), .rsp_way_o(rsp_way), .rsp_victim_valid_o(rsp_vv),
    .busy_o(busy), .tag_line_o(tag_line),
    .tag_set_bitvec_i(m_bitvec), .tag_valid_i(m_hit), .tag_set_enc_i(m_enc),
    .tag_ins_line_o(ins_line), .tag_ins_way_o(ins_way),
    .tag_insert_o(ins), .tag_insert_present_o(ins_pres)
  );

  // Tag array model: valid bits and tags per set/way. Seeded with valid
  // garbage (tag = way+1) so an incomplete sweep shows up as stray hits.
  logic [3:0]  mv [256];
  logic [12:0] mt [256][4];
  bit          seeded = 1'b0;
  logic [7:0]  m_idx;
  logic [12:0] m_tag;
  assign m_idx = tag_line[7:0];
  assign m_tag = tag_line[20:8];

  always_comb begin
    m_bitvec = mv[m_idx];
    m_hit    = 1'b0;
    m_enc    = 2'd0;
    for (int w = 3; w >= 0; w--)
      if (mv[m_idx][w] && mt[m_idx][w] == m_tag) begin
        m_hit = 1'b1;
        m_enc = w[1:0];
      end
  end

  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < 256; i++) begin
        mv[i] <= 4'hF;
        for (int w = 0; w < 4; w++) mt[i][w] <= 13'(w + 1);
      end
      seeded <= 1'b1;
    end else if (ins) begin
      mv[ins_line[7:0]][ins_way] <= ins_pres;
      mt[ins_line[7:0]][ins_way] <= ins_line[20:8];
    end
  end

  // Observation record of one request, filled by do_req.
  logic          o_rdy, o_ins, o_pres, o_rv, o_hit, o_vv;
  logic [1:0]    o_iway, o_way;
  logic [LW-1:0] o_iline;

  // Drive one request from IDLE with rsp_ready_i=1; returns at the next IDLE.
  task automatic do_req(input logic [LW-1:0] line, input logic [1:0] op);
    o_rdy = req_ready; req_valid = 1'b1; req_line = line; req_op = op;
    @(negedge clk);
    req_valid = 1'b0;
    o_ins = ins; o_pres = ins_pres; o_iway = ins_way; o_iline = ins_line;
    @(negedge clk);
    o_rv = rsp_valid; o_hit = rsp_hit; o_way = rsp_way; o_vv = rsp_vv;
    @(negedge clk);
  endtask

  // Sweep observation: counts busy cycles and verifies each INIT write address.
  int            s_n;
  logic          s_seq_ok, s_any_rsp;
  logic [LW-1:0] s_last_line;
  logic [1:0]    s_last_way;

  task automatic watch_sweep();
    s_n = 0; s_seq_ok = 1'b1; s_any_rsp = 1'b0;
    while (busy === 1'b1 && s_n < 2000) begin
      if (ins !== 1'b1 || ins_pres !== 1'b0 || ins_line !== LW'(s_n >> 2) ||
          ins_way !== 2'(s_n)) s_seq_ok = 1'b0;
      if (rsp_valid !== 1'b0) s_any_rsp = 1'b1;
      s_last_line = ins_line; s_last_way = ins_way;
      s_n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_busy got=%b exp=1", busy); end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (ins !== 1'b0) begin failures++; $display("FAIL rst_insert got=%b exp=0", ins); end
    checks++; if ({rsp_hit, rsp_way, rsp_vv} !== 4'b0) begin failures++; $display("FAIL rst_rsp_fields got=%b exp=0000", {rsp_hit, rsp_way, rsp_vv}); end
    rst = 1'b0;
    #1;
    watch_sweep();
    checks++; if (s_n !== 1024) begin failures++; $display("FAIL sweep_len got=%0d exp=1024", s_n); end
    checks++; if (s_seq_ok !== 1'b1) begin failures++; $display("FAIL sweep_seq got=%b exp=1", s_seq_ok); end
    checks++; if (s_last_line !== LW'(8'hFF) || s_last_way !== 2'd3) begin failures++; $display("FAIL sweep_last got=%h/%0d exp=0000ff/3", s_last_line, s_last_way); end
    checks++; if (req_ready !== 1'b1 || ins !== 1'b0) begin failures++; $display("FAIL post_sweep_idle got=%b%b exp=10", req_ready, ins); end
    do_req(21'h000123, 2'b00);
    checks++; if (o_rdy !== 1'b1 || o_rv !== 1'b1 || o_hit !== 1'b0 || o_ins !== 1'b0) begin failures++; $display("FAIL init_miss_a got=%b%b%b%b exp=1100", o_rdy, o_rv, o_hit, o_ins); end
    do_req(21'h000300, 2'b00);
    checks++; if (o_hit !== 1'b0 || o_way !== 2'd0) begin failures++; $display("FAIL init_miss_b got=%b/%0d exp=0/0", o_hit, o_way); end
    do_req(21'h1FFFFF, 2'b11);
    checks++; if (o_hit !== 1'b0 || o_ins !== 1'b0) begin failures++; $display("FAIL init_miss_c got=%b%b exp=00", o_hit, o_ins); end
  endtask

  task automatic test_alloc();
    do_req(21'h000123, 2'b01);
    checks++; if ({o_hit, o_way, o_vv} !== 4'b0000) begin failures++; $display("FAIL alloc1_rsp got=%b exp=0000", {o_hit, o_way, o_vv}); end
    checks++; if ({o_ins, o_pres, o_iway} !== 4'b1100 || o_iline !== 21'h000123) begin failures++; $display("FAIL alloc1_write got=%b%b%0d %h exp=11 0 000123", o_ins, o_pres, o_iway, o_iline); end
    do_req(21'h000123, 2'b00);
    checks++; if (o_hit !== 1'b1 || o_way !== 2'd0 || o_ins !== 1'b0) begin failures++; $display("FAIL lookup1 got=%b/%0d/%b exp=1/0/0", o_hit, o_way, o_ins); end
    do_req(21'h000223, 2'b01);
    checks++; if (o_hit !== 1'b0 || o_way !== 2'd1 || o_vv !== 1'b0 || o_iway !== 2'd1) begin failures++; $display("FAIL alloc2 got=%b/%0d/%b/%0d exp=0/1/0/1", o_hit, o_way, o_vv, o_iway); end
  endtask

  task automatic test_plru();
    do_req(21'h000323, 2'b01);
    checks++; if (o_way !== 2'd2 || o_vv !== 1'b0) begin failures++; $display("FAIL alloc3 got=%0d/%b exp=2/0", o_way, o_vv); end
    do_req(21'h000423, 2'b01);
    checks++; if (o_way !== 2'd3 || o_vv !== 1'b0) begin failures++; $display("FAIL alloc4 got=%0d/%b exp=3/0", o_way, o_vv); end
    do_req(21'h000123, 2'b00);
    checks++; if (o_hit !== 1'b1 || o_way !== 2'd0) begin failures++; $display("FAIL touch0 got=%b/%0d exp=1/0", o_hit, o_way); end
    do_req(21'h000523, 2'b01);
    checks++; if ({o_hit, o_way, o_vv} !== 4'b0101) begin failures++; $display("FAIL evict got=%b exp=0101", {o_hit, o_way, o_vv}); end
    checks++; if ({o_ins, o_pres, o_iway} !== 4'b1110 || o_iline !== 21'h000523) begin failures++; $display("FAIL evict_write got=%b %h exp=1110 000523", {o_ins, o_pres, o_iway}, o_iline); end
    do_req(21'h000323, 2'b00);
    checks++; if (o_hit !== 1'b0) begin failures++; $display("FAIL evicted_gone got=%b exp=0", o_hit); end
    do_req(21'h000523, 2'b00);
    checks++; if (o_hit !== 1'b1 || o_way !== 2'd2) begin failures++; $display("FAIL new_present got=%b/%0d exp=1/2", o_hit, o_way); end
    do_req(21'h000123, 2'b01);
    checks++; if (o_hit !== 1'b1 || o_way !== 2'd0 || o_ins !== 1'b0 || o_vv !== 1'b0) begin failures++; $display("FAIL alloc_hit got=%b/%0d/%b/%b exp=1/0/0/0", o_hit, o_way, o_ins, o_vv); end
  endtask

  task automatic test_invalidate();
    do_req(21'h000223, 2'b10);
    checks++; if (o_hit !== 1'b1 || o_way !== 2'd1) begin failures++; $display("FAIL inv_rsp got=%b/%0d exp=1/1", o_hit, o_way); end
    checks++; if ({o_ins, o_pres, o_iway} !== 4'b1001 || o_iline !== 21'h000223) begin failures++; $display("FAIL inv_write got=%b %h exp=1001 000223", {o_ins, o_pres, o_iway}, o_iline); end
    do_req(21'h000223, 2'b00);
    checks++; if (o_hit !== 1'b0) begin failures++; $display("FAIL inv_gone got=%b exp=0", o_hit); end
    do_req(21'h000923, 2'b10);
    checks++; if (o_hit !== 1'b0 || o_way !== 2'd0 || o_ins !== 1'b0) begin failures++; $display("FAIL inv_absent got=%b/%0d/%b exp=0/0/0", o_hit, o_way, o_ins); end
    do_req(21'h000623, 2'b01);
    checks++; if (o_way !== 2'd1 || o_vv !== 1'b0) begin failures++; $display("FAIL refill_hole got=%0d/%b exp=1/0", o_way, o_vv); end
    do_req(21'h000123, 2'b11);
    checks++; if (o_hit !== 1'b1 || o_way !== 2'd0 || o_ins !== 1'b0) begin failures++; $display("FAIL op11_lookup got=%b/%0d/%b exp=1/0/0", o_hit, o_way, o_ins); end
  endtask

  task automatic test_stall();
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_line = 21'h000423; req_op = 2'b00;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++; if ({rsp_valid, rsp_hit, rsp_way, rsp_vv, req_ready} !== 6'b111100) begin failures++; $display("FAIL stall_hold[%0d] got=%b exp=111100", i, {rsp_valid, rsp_hit, rsp_way, rsp_vv, req_ready}); end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL stall_release got=%b%b exp=10", req_ready, rsp_valid); end
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1; req_line = 21'h000123; req_op = 2'b00;
    for (int c = 0; c < 12; c++) begin
      checks++; if (req_ready !== (c % 3 == 0)) begin failures++; $display("FAIL b2b_ready[%0d] got=%b exp=%b", c, req_ready, c % 3 == 0); end
      checks++; if (rsp_valid !== (c % 3 == 2)) begin failures++; $display("FAIL b2b_rsp[%0d] got=%b exp=%b", c, rsp_valid, c % 3 == 2); end
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    // reset while in LOOKUP
    req_valid = 1'b1; req_line = 21'h000123; req_op = 2'b00;
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++; if ({rsp_valid, busy, req_ready, ins} !== 4'b0100) begin failures++; $display("FAIL rst_lookup got=%b exp=0100", {rsp_valid, busy, req_ready, ins}); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    watch_sweep();
    checks++; if (s_n !== 1024 || s_seq_ok !== 1'b1 || s_any_rsp !== 1'b0) begin failures++; $display("FAIL resweep1 got=%0d/%b/%b exp=1024/1/0", s_n, s_seq_ok, s_any_rsp); end
    do_req(21'h000123, 2'b00);
    checks++; if (o_hit !== 1'b0) begin failures++; $display("FAIL cleared1 got=%b exp=0", o_hit); end
    do_req(21'h000123, 2'b01);
    checks++; if (o_way !== 2'd0 || o_vv !== 1'b0) begin failures++; $display("FAIL realloc got=%0d/%b exp=0/0", o_way, o_vv); end
    // reset while a response is pending
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_line = 21'h000123; req_op = 2'b00;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_hit !== 1'b1) begin failures++; $display("FAIL pre_rst_resp got=%b%b exp=11", rsp_valid, rsp_hit); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_hit, busy, req_ready} !== 4'b0010) begin failures++; $display("FAIL rst_resp got=%b exp=0010", {rsp_valid, rsp_hit, busy, req_ready}); end
    rsp_ready = 1'b1; rst = 1'b0;
    #1;
    watch_sweep();
    checks++; if (s_n !== 1024 || s_seq_ok !== 1'b1 || s_any_rsp !== 1'b0) begin failures++; $display("FAIL resweep2 got=%0d/%b/%b exp=1024/1/0", s_n, s_seq_ok, s_any_rsp); end
    do_req(21'h000123, 2'b00);
    checks++; if (o_hit !== 1'b0 || o_rv !== 1'b1) begin failures++; $display("FAIL cleared2 got=%b%b exp=01", o_hit, o_rv); end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_line = '0; req_op = 2'b00; rsp_ready = 1'b1;
    test_reset();
    test_alloc();
    test_plru();
    test_invalidate();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l2_tag_ctrl.md
Name: l2_tag_ctrl

Overview:
- Sequencing controller for the 4-way, 256-set L2 tag array. Accepts one tag operation at a time (lookup, allocate-on-miss, invalidate), drives the array's combinational read port and its single write port, and returns hit/way/victim information.
- Owns per-set tree pseudo-LRU state.
- After reset, performs an initialisation sweep that invalidates every way of every set.
- Sits between the L2 request pipeline and the tag array.

Parameters:
- TL_AW, 28, physical address width. Line address is TL_AW-7 bits [TL_AW-8:0]; index is [7:0]; tag is [TL_AW-8:8].

Ports:
- l2_clock_i  in  1  sole clock, rising edge.
- l2_reset_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  controller can accept a request.
- req_line_i  in  TL_AW-7  request line address.
- req_op_i  in  2  00 lookup, 01 allocate-on-miss, 10 invalidate, 11 reserved (treated as lookup).
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed.
- rsp_hit_o  out  1  line was present.
- rsp_way_o  out  2  hit way, or allocated way on a miss.
- rsp_victim_valid_o  out  1  allocation displaced a valid way.
- busy_o  out  1  init sweep in progress.
- tag_line_o  out  TL_AW-7  array read address.
- tag_set_bitvec_i  in  4  per-way valid bits from the array.
- tag_valid_i  in  1  hit indication from the array.
- tag_set_enc_i  in  2  hit way from the array.
- tag_ins_line_o  out  TL_AW-7  array write address.
- tag_ins_way_o  out  2  array write way.
- tag_insert_o  out  1  array write strobe.
- tag_insert_present_o  out  1  valid bit to write.

Behaviour:
- Reset: synchronous on l2_clock_i while l2_reset_i=1, highest priority. Applies mid-operation and abandons any in-flight request without a response. After reset: state=INIT, sweep counter=0, req_ready_o=0, rsp_valid_o=0, rsp_hit_o=0, rsp_way_o=0, rsp_victim_valid_o=0, tag_insert_o=0, busy_o=1.
- States: INIT, IDLE, LOOKUP, RESP.
- INIT:
  - 10-bit counter c. Each cycle: tag_insert_o=1, tag_insert_present_o=0, tag_ins_line_o={0, c[9:2]}, tag_ins_way_o=c[1:0].
  - When c[1:0]==0, plru[c[9:2]] is set to 3'b000.
  - After c==1023 is written, go to IDLE. The sweep takes exactly 1024 cycles; busy_o drops in the same cycle as the transition.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i: capture line/op into registers and go to LOOKUP.
  - tag_insert_o=0.
- LOOKUP (exactly 1 cycle):
  - tag_line_o = captured line. Sample tag_valid_i, tag_set_enc_i and tag_set_bitvec_i.
  - Hit, any op except invalidate: rsp_hit_o=1, rsp_way_o=tag_set_enc_i, no write, PLRU touch on that way.
  - Hit, invalidate: rsp_hit_o=1, rsp_way_o=hit way. Write present=0 to that way. PLRU unchanged.
  - Miss, lookup/invalidate: rsp_hit_o=0, rsp_way_o=0, no write.
  - Miss, allocate:
    - Victim is the lowest-numbered way with set_bitvec bit = 0.
    - If all 4 ways are valid, victim is the PLRU way and rsp_victim_valid_o=1.
    - Write present=1 of the line into the victim way. PLRU touch on the victim.
  - rsp_victim_valid_o=0 in all cases other than the all-valid allocate.
  - Go to RESP.
- RESP:
  - rsp_valid_o=1; outputs held stable until rsp_ready_i. Then go to IDLE.
  - req_ready_o=0 in LOOKUP and RESP.
  - Latency: accept at cycle N, array read/write at N+1, rsp_valid_o at N+2. Peak throughput is 1 request per 3 cycles.
- PLRU (3 bits per set, b0 root):
  - Victim: b0=0 selects ways 0/1, then b1=0 selects way 0 else way 1. b0=1 selects ways 2/3, then b2=0 selects way 2 else way 3.
  - Touch way w: b0 = (w<2). If w<2, b1 = (w==0). Otherwise b2 = (w==2).
  - PLRU register write and tag write share the LOOKUP cycle.
- tag_insert_o is a single-cycle pulse, high only in INIT and LOOKUP write cases.
- tag_ins_line_o equals the captured line in LOOKUP.

Test Plan:
- Reset, then hold l2_reset_i low -> busy_o=1 and tag_insert_o=1 for exactly 1024 cycles; last write has index 0xFF, way 3. Then req_ready_o=1 and every lookup misses.
- Allocate line 0x000123 into an empty set 0x23 -> rsp_hit_o=0, rsp_way_o=0, rsp_victim_valid_o=0. A following lookup of 0x000123 returns hit with way 0. A second allocate of 0x000223 returns way 1.
- Fill set 0x23 with tags 1..4 (ways 0..3). Touch way 0 via lookup, then allocate tag 5 -> PLRU victim way 2 and rsp_victim_valid_o=1. Lookup of tag 3 then misses.
- Invalidate a present line in way 1 -> hit=1, way=1, single write with present=0. Re-lookup misses. Invalidating an absent line produces no write.
- Hold rsp_ready_i=0 for 5 cycles -> response stays stable and req_ready_o=0. Release it -> IDLE on the next cycle, and back-to-back requests see 3-cycle spacing.
- Assert l2_reset_i during LOOKUP and during RESP -> no response is ever produced, the INIT sweep restarts from c=0, and PLRU/valid bits are cleared.
